// File: rtl/host_mbox.sv
// Bus-side mailbox between a core and a host: a TX FIFO the core fills and the host drains, an RX FIFO the reverse.
// Optional interrupt output and CTRL register are built when HOST_MBOX_IRQ_EN is defined.
module host_mbox_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [31:0] i_push_data,
    input  logic        i_pop,
    output logic [31:0] o_head,
    output logic [7:0]  o_count,
    output logic        o_full,
    output logic        o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Full/empty come from registered count, so a same-cycle pop never frees room for a push.
    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_head  = o_empty ? '0 : mem[rd_ptr];
    assign o_count = 8'(count);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_push_data;
    end
endmodule

module host_mbox #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_wr_en,
    input  logic [3:0]  i_b_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
`ifdef HOST_MBOX_IRQ_EN
    output logic        o_irq,
`endif
    input  logic        i_h_wr_valid,
    output logic        o_h_wr_ready,
    input  logic [31:0] i_h_wr_data,
    output logic        o_h_rd_valid,
    input  logic        i_h_rd_ready,
    output logic [31:0] o_h_rd_data
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_TX, S_ACK} state_t;

    state_t      state;
    logic [31:0] held_data;
    logic [31:0] masked;
    logic [31:0] rd_val;
    logic [31:0] status;
    logic [1:0]  off;
    logic        accept;
    logic        tx_push, tx_full, tx_empty;
    logic [31:0] tx_push_data;
    logic [7:0]  tx_count;
    logic        rx_pop, rx_full, rx_empty;
    logic [31:0] rx_head;
    logic [7:0]  rx_count;
    logic        unused_addr;
`ifdef HOST_MBOX_IRQ_EN
    logic [1:0]  ctrl;
`endif

    assign unused_addr = ^{i_addr[31:4], i_addr[1:0]};
    assign off    = i_addr[3:2];
    assign accept = (state == S_IDLE) && i_cs;
    assign status = {8'h00, tx_count, rx_count, 4'h0, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        masked = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (i_b_en[b]) masked[8*b +: 8] = i_wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            2'd1: rd_val = rx_head;
            2'd2: rd_val = status;
`ifdef HOST_MBOX_IRQ_EN
            2'd3: rd_val = {30'b0, ctrl};
`endif
            default: rd_val = '0;
        endcase
    end

    // A stalled write pushes its held word the first cycle TX shows room.
    assign tx_push = (accept && i_wr_en && off == 2'd0 && !tx_full) ||
                     (state == S_WAIT_TX && !tx_full);
    assign tx_push_data = (state == S_WAIT_TX) ? held_data : masked;
    assign rx_pop = accept && !i_wr_en && off == 2'd1;

    host_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_push(tx_push), .i_push_data(tx_push_data),
        .i_pop(i_h_rd_ready), .o_head(o_h_rd_data),
        .o_count(tx_count), .o_full(tx_full), .o_empty(tx_empty)
    );

    host_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_push(i_h_wr_valid), .i_push_data(i_h_wr_data),
        .i_pop(rx_pop), .o_head(rx_head),
        .o_count(rx_count), .o_full(rx_full), .o_empty(rx_empty)
    );

    assign o_h_wr_ready = !rx_full;
    assign o_h_rd_valid = !tx_empty;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            held_data <= '0;
            o_ack     <= 1'b0;
            o_rd_data <= '0;
`ifdef HOST_MBOX_IRQ_EN
            ctrl      <= '0;
`endif
        end else begin
            o_ack     <= 1'b0;
            o_rd_data <= '0;
            case (state)
                S_IDLE: begin
                    if (i_cs) begin
                        if (i_wr_en && off == 2'd0 && tx_full) begin
                            held_data <= masked;
                            state     <= S_WAIT_TX;
                        end else begin
                            state <= S_ACK;
                            o_ack <= 1'b1;
                            if (!i_wr_en) o_rd_data <= rd_val;
                        end
`ifdef HOST_MBOX_IRQ_EN
                        if (i_wr_en && off == 2'd3) ctrl <= i_wr_data[1:0];
`endif
                    end
                end
                S_WAIT_TX: begin
                    if (!tx_full) begin
                        state <= S_ACK;
                        o_ack <= 1'b1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HOST_MBOX_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_irq <= 1'b0;
        else        o_irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty);
    end
`endif
endmodule

// File: doc/host_mbox.md
HOST_MBOX -- requirements
Module: host_mbox

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: entries per FIFO; power of two, 2..16.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_cs  input  1  bus request from the core.
REQ-005 SHALL have port i_wr_en  input  1  1=write, 0=read.
REQ-006 SHALL have port i_b_en  input  4  byte enables.
REQ-007 SHALL have port i_wr_data  input  32  bus write data.
REQ-008 SHALL have port i_addr  input  32  bus address; only i_addr[3:2] decoded.
REQ-009 SHALL have port o_ack  output  1  single-cycle completion pulse.
REQ-010 SHALL have port o_rd_data  output  32  read data, valid while o_ack=1.
REQ-011 SHALL have port i_h_wr_valid / o_h_wr_ready / i_h_wr_data  in/out/in  1/1/32  host push into RX FIFO.
REQ-012 SHALL have port o_h_rd_valid / i_h_rd_ready / o_h_rd_data  out/in/out  1/1/32  host drain of TX FIFO.

Function
REQ-013 Map (offset i_addr[3:2]): 0 TO_HOST (W push TX, R 0); 1 FROM_HOST (R pop RX, W ignored); 2 STATUS (R only); 3 CTRL/unmapped.
REQ-014 STATUS SHALL be {8'b0, tx_count[7:0], rx_count[7:0], 4'b0, rx_empty, rx_full, tx_empty, tx_full}.
REQ-015 FSM states IDLE, WAIT_TX, ACK; a request is accepted in IDLE when i_cs=1.
REQ-016 IDLE->ACK on any accepted request except TO_HOST write with TX full; that case IDLE->WAIT_TX.
REQ-017 WAIT_TX->ACK in the cycle TX is not full, pushing the held word then; ACK->IDLE unconditionally.
REQ-018 o_ack SHALL be 1 exactly in ACK: latency 1 cycle unstalled, 1+stall cycles otherwise; back-to-back requests yield ack every 2nd cycle.
REQ-019 Request fields SHALL be captured at acceptance; i_cs changes during WAIT_TX/ACK are ignored.
REQ-020 TO_HOST push word SHALL zero byte lanes whose i_b_en bit is 0.
REQ-021 FROM_HOST read: RX non-empty -> return head and pop at acceptance; empty -> return 0, no pop, no stall.
REQ-022 o_rd_data SHALL be 0 whenever o_ack=0 and for all writes.
REQ-023 o_h_wr_ready = !rx_full; push when i_h_wr_valid & o_h_wr_ready.
REQ-024 o_h_rd_valid = !tx_empty; o_h_rd_data = TX head (0 when empty); pop when valid & i_h_rd_ready.
REQ-025 Full/empty SHALL be evaluated from registered state: a push into a full FIFO is refused even if a pop occurs the same cycle; a pop from an empty FIFO is a no-op.
REQ-026 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both occur, count unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; counts range 0..FIFO_DEPTH.

Reset
REQ-028 While i_rst=0: FSM=IDLE, both FIFOs empty, counts 0, o_ack=0, o_rd_data=0, o_h_rd_valid=0, o_h_rd_data=0, o_h_wr_ready=1.
REQ-029 Reset during WAIT_TX or ACK SHALL drop the request with no ack and no push.

Configuration
REQ-030 With HOST_MBOX_IRQ_EN defined: port o_irq (output 1) and CTRL at offset 3 (bit0 rx_irq_en, bit1 tx_irq_en, RW, reset 0) SHALL exist.
REQ-031 With HOST_MBOX_IRQ_EN: o_irq registered = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), one-cycle lag from state change.
REQ-032 Without HOST_MBOX_IRQ_EN: no o_irq port, offset 3 reads 0, writes ignored.

Verification
REQ-033 Write 0xDEADBEEF offset 0, b_en=4'hF, TX empty -> o_ack next cycle, o_h_rd_valid=1, o_h_rd_data=0xDEADBEEF.
REQ-034 Write 0x11223344 offset 0, b_en=4'b0101 -> pushed word 0x00220044.
REQ-035 FIFO_DEPTH=4, 4 writes with host not draining, 5th write -> WAIT_TX; assert i_h_rd_ready one cycle -> ack following cycle, tx_count=4.
REQ-036 Host pushes 0xA5A5A5A5 then bus reads offset 1 twice -> first o_rd_data=0xA5A5A5A5, second 0, both acked latency 1.
REQ-037 Read STATUS after reset -> 0x0000_000A; RX full with simultaneous host push and bus pop -> push refused, rx_count=3.
REQ-038 Assert i_rst=0 during WAIT_TX -> no ack, tx_count=0, o_h_wr_ready=1; with HOST_MBOX_IRQ_EN, CTRL=1 and one host push -> o_irq=1 next cycle.
